alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller on the initiator side of the datapath ALU interface. It accepts one decoded MIPS arithmetic/logic/branch-compare request over a valid/ready handshake, then forms and registers the ALU operands and 3-bit `aluOp`. One cycle later it captures the ALU's result, zero flag and overflow flag, and returns them over a second valid/ready handshake with trap and illegal-op status. It sits between instruction decode/register read and writeback, driving the existing combinational ALU.

---
 rtl/alu_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode/register-read and writeback: decodes one MIPS
// ALU-class request, drives the combinational ALU for a cycle, returns the result.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [5:0]            reqOpcode,
  input  logic [5:0]            reqFunct,
  input  logic [DATA_WIDTH-1:0] reqRs,
  input  logic [DATA_WIDTH-1:0] reqRt,
  input  logic [15:0]           reqImm,
  output logic [DATA_WIDTH-1:0] aluOperandA,
  output logic [DATA_WIDTH-1:0] aluOperandB,
  output logic [2:0]            aluOp,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic                  aluZero,
  input  logic                  aluOverflow,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspResult,
  output logic                  rspZero,
  output logic                  rspTrap,
  output logic                  rspIllegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  state_t state, state_next;
  logic   accept;
  logic   trap_en, illegal;

  logic [DATA_WIDTH-1:0] dec_a, dec_b, imm_sext, imm_zext;
  logic [2:0]            dec_op;
  logic                  dec_trap_en, dec_illegal;

  assign accept   = reqValid & reqReady;
  assign imm_sext = DATA_WIDTH'($signed(reqImm));
  assign imm_zext = DATA_WIDTH'(reqImm);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (accept)   state_next = EXEC;
      EXEC:                  state_next = RESP;
      RESP:    if (rspReady) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    reqReady = (state == IDLE) & rst_n;
    rspValid = (state == RESP);
  end

  always_comb begin
    dec_a       = reqRs;
    dec_b       = reqRt;
    dec_op      = OP_ADD;
    dec_trap_en = 1'b0;
    dec_illegal = 1'b0;
    case (reqOpcode)
      6'h00: begin
        case (reqFunct)
          6'h20: dec_trap_en = 1'b1;
          6'h21: ;
          6'h22: begin dec_op = OP_SUB; dec_trap_en = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h26: dec_op = OP_XOR;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_b = imm_sext; dec_trap_en = 1'b1; end
      6'h09: dec_b = imm_sext;
      6'h0C: begin dec_b = imm_zext; dec_op = OP_AND; end
      6'h0D: begin dec_b = imm_zext; dec_op = OP_OR;  end
      6'h0E: begin dec_b = imm_zext; dec_op = OP_XOR; end
      6'h04, 6'h05: dec_op = OP_SUB;
      default: dec_illegal = 1'b1;
    endcase
    // Illegal requests still run through the ALU, but with neutral operands.
    if (dec_illegal) begin
      dec_a  = '0;
      dec_b  = '0;
      dec_op = OP_ADD;
    end
  end

  // NOTE: these are plain registers, not a memory, so all of them are
  // cleared by the synchronous reset and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aluOperandA <= '0;
      aluOperandB <= '0;
      aluOp       <= OP_ADD;
      trap_en     <= 1'b0;
      illegal     <= 1'b0;
      rspResult   <= '0;
      rspZero     <= 1'b0;
      rspTrap     <= 1'b0;
      rspIllegal  <= 1'b0;
    end else begin
      if (accept) begin
        aluOperandA <= dec_a;
        aluOperandB <= dec_b;
        aluOp       <= dec_op;
        trap_en     <= dec_trap_en;
        illegal     <= dec_illegal;
      end
      if (state == EXEC) begin
        rspZero    <= aluZero;
        rspTrap    <= trap_en & aluOverflow;
        rspIllegal <= illegal;
        rspResult  <= ((trap_en & aluOverflow) | illegal) ? '0 : aluResult;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_issue_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reqValid, reqReady;
  logic [5:0]    reqOpcode, reqFunct;
  logic [DW-1:0] reqRs, reqRt;
  logic [15:0]   reqImm;
  logic [DW-1:0] aluOperandA, aluOperandB, aluResult;
  logic [2:0]    aluOp;
  logic          aluZero, aluOverflow;
  logic          rspValid, rspReady;
  logic [DW-1:0] rspResult;
  logic          rspZero, rspTrap, rspIllegal;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          trap;
    logic          illegal;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqOpcode(reqOpcode), .reqFunct(reqFunct),
    .reqRs(reqRs), .reqRt(reqRt), .reqImm(reqImm),
    .aluOperandA(aluOperandA), .aluOperandB(aluOperandB), .aluOp(aluOp),
    .aluResult(aluResult), .aluZero(aluZero), .aluOverflow(aluOverflow),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspResult(rspResult), .rspZero(rspZero),
    .rspTrap(rspTrap), .rspIllegal(rspIllegal)
  );

  // Behavioural model of the combinational datapath ALU.
  always_comb begin
    aluResult   = '0;
    aluOverflow = 1'b0;
    case (aluOp)
      3'b000: begin
        aluResult   = aluOperandA + aluOperandB;
        aluOverflow = (aluOperandA[DW-1] == aluOperandB[DW-1]) &&
                      (aluResult[DW-1] != aluOperandA[DW-1]);
      end
      3'b001: begin
        aluResult   = aluOperandA - aluOperandB;
        aluOverflow = (aluOperandA[DW-1] != aluOperandB[DW-1]) &&
                      (aluResult[DW-1] != aluOperandA[DW-1]);
      end
      3'b010: aluResult = aluOperandA & aluOperandB;
      3'b011: aluResult = aluOperandA | aluOperandB;
      3'b100: aluResult = aluOperandA ^ aluOperandB;
      default: aluResult = '0;
    endcase
    aluZero = (aluResult == '0);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [DW-1:0] r, input logic z, input logic t, input logic i);
    rsp_t x;
    x.result = r; x.zero = z; x.trap = t; x.illegal = i;
    return x;
  endfunction

  // One full transaction; stall > 0 holds rspReady low that many cycles while
  // a follow-on xor request waits on reqValid.
  task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [DW-1:0] rs, input logic [DW-1:0] rt, input logic [15:0] imm,
                       input logic [DW-1:0] e_a, input logic [DW-1:0] e_b, input logic [2:0] e_op,
                       input rsp_t e_rsp, input int stall);
    int   waited;
    rsp_t exp;
    reqOpcode = op; reqFunct = fn; reqRs = rs; reqRt = rt; reqImm = imm;
    reqValid  = 1'b1;
    #0;
    check({name, " reqReady idle"}, reqReady, 1'b1);
    sb.push_back(e_rsp);
    @(posedge clk); #1;
    reqValid = 1'b0;
    check({name, " aluOperandA"}, aluOperandA, e_a);
    check({name, " aluOperandB"}, aluOperandB, e_b);
    check({name, " aluOp"}, aluOp, e_op);
    check({name, " rspValid in EXEC"}, rspValid, 1'b0);
    check({name, " reqReady in EXEC"}, reqReady, 1'b0);
    waited = 0;
    while (!rspValid && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, " response latency"}, waited, 1);
    exp = sb.pop_front();
    check({name, " rspResult"}, rspResult, exp.result);
    check({name, " rspZero"}, rspZero, exp.zero);
    check({name, " rspTrap"}, rspTrap, exp.trap);
    check({name, " rspIllegal"}, rspIllegal, exp.illegal);
    if (stall > 0) begin
      reqOpcode = 6'h00; reqFunct = 6'h26; reqRs = 32'h0000FF00; reqRt = 32'h00000FF0;
      reqValid  = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({name, " stall rspValid"}, rspValid, 1'b1);
        check({name, " stall rspResult"}, rspResult, exp.result);
        check({name, " stall rspIllegal"}, rspIllegal, exp.illegal);
        check({name, " stall reqReady"}, reqReady, 1'b0);
      end
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    check({name, " rspValid after handshake"}, rspValid, 1'b0);
    check({name, " reqReady after handshake"}, reqReady, 1'b1);
    if (stall > 0) check({name, " no accept on handshake edge"}, aluOp, e_op);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst_n = 1'b0; reqValid = 1'b0; rspReady = 1'b0;
    reqOpcode = '0; reqFunct = '0; reqRs = '0; reqRt = '0; reqImm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset reqReady", reqReady, 1'b0);
    check("reset rspValid", rspValid, 1'b0);
    check("reset aluOp", aluOp, 3'b000);
    check("reset rspResult", rspResult, '0);
    rst_n = 1'b1;

    issue("add_ovf", 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0,
          32'h7FFFFFFF, 32'h1, 3'b000, mk(32'h0, 1'b0, 1'b1, 1'b0), 0);
    issue("addu", 6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0,
          32'h7FFFFFFF, 32'h1, 3'b000, mk(32'h80000000, 1'b0, 1'b0, 1'b0), 0);
    issue("sub_ovf", 6'h00, 6'h22, 32'h80000000, 32'h1, 16'h0,
          32'h80000000, 32'h1, 3'b001, mk(32'h0, 1'b0, 1'b1, 1'b0), 0);
    issue("subu", 6'h00, 6'h23, 32'd10, 32'd3, 16'h0,
          32'd10, 32'd3, 3'b001, mk(32'd7, 1'b0, 1'b0, 1'b0), 0);
    issue("and", 6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 16'h0,
          32'h0000F0F0, 32'h0000FF00, 3'b010, mk(32'h0000F000, 1'b0, 1'b0, 1'b0), 0);
    issue("addi", 6'h08, 6'h00, 32'd5, 32'h0, 16'hFFFF,
          32'd5, 32'hFFFFFFFF, 3'b000, mk(32'd4, 1'b0, 1'b0, 1'b0), 0);
    issue("ori", 6'h0D, 6'h00, 32'h0000F000, 32'h0, 16'h8001,
          32'h0000F000, 32'h00008001, 3'b011, mk(32'h0000F001, 1'b0, 1'b0, 1'b0), 0);
    issue("andi", 6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8001,
          32'hFFFFFFFF, 32'h00008001, 3'b010, mk(32'h00008001, 1'b0, 1'b0, 1'b0), 0);
    issue("xori", 6'h0E, 6'h00, 32'h1, 32'h0, 16'h0001,
          32'h1, 32'h1, 3'b100, mk(32'h0, 1'b1, 1'b0, 1'b0), 0);
    issue("beq", 6'h04, 6'h00, 32'd7, 32'd7, 16'h0,
          32'd7, 32'd7, 3'b001, mk(32'h0, 1'b1, 1'b0, 1'b0), 0);
    issue("bne", 6'h05, 6'h00, 32'd7, 32'd8, 16'h0,
          32'd7, 32'd8, 3'b001, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0), 0);
    issue("bad_funct", 6'h00, 6'h27, 32'd3, 32'd4, 16'h0,
          32'h0, 32'h0, 3'b000, mk(32'h0, 1'b1, 1'b0, 1'b1), 0);
    issue("bad_opcode", 6'h3F, 6'h00, 32'd5, 32'd6, 16'h1234,
          32'h0, 32'h0, 3'b000, mk(32'h0, 1'b1, 1'b0, 1'b1), 3);
    issue("xor_pending", 6'h00, 6'h26, 32'h0000FF00, 32'h00000FF0, 16'h0,
          32'h0000FF00, 32'h00000FF0, 3'b100, mk(32'h0000F0F0, 1'b0, 1'b0, 1'b0), 0);

    // Reset while in EXEC abandons the operation.
    reqOpcode = 6'h00; reqFunct = 6'h25; reqRs = 32'h0000F0F0; reqRt = 32'h0000FF00;
    reqValid  = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    check("abort accepted aluOp", aluOp, 3'b011);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort aluOperandA", aluOperandA, '0);
    check("abort aluOperandB", aluOperandB, '0);
    check("abort aluOp", aluOp, 3'b000);
    check("abort rspResult", rspResult, '0);
    check("abort rspZero", rspZero, 1'b0);
    check("abort rspTrap", rspTrap, 1'b0);
    check("abort rspIllegal", rspIllegal, 1'b0);
    check("abort rspValid", rspValid, 1'b0);
    check("abort reqReady in reset", reqReady, 1'b0);
    rst_n = 1'b1;
    #1;
    check("abort reqReady after release", reqReady, 1'b1);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rspValid) seen++;
    end
    check("abort no response", seen, 0);

    issue("post_reset_addiu", 6'h09, 6'h00, 32'd1, 32'h0, 16'hFFFE,
          32'd1, 32'hFFFFFFFE, 3'b000, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0), 0);
    check("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
